mano_timing_ctrl: RTL
=====================

MANO_TIMING_CTRL -- requirements
Module: mano_timing_ctrl

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset, with ports listed as: clk input 1 rising-edge clock; rst input 1 async active-high reset.
REQ-002 The block SHALL have these ports:
- ir input 16: current IR contents.
- start input 1: sets run flip-flop S.
- fgi input 1: input flag, used only under MANO_INTERRUPT_EN.
- fgo input 1: output flag, used only under MANO_INTERRUPT_EN.
- T output 16: one-hot timing, T[n] asserted when SC==n.
- D output 8: one-hot decode of ir[14:12].
- I output 1: latched indirect bit.
- running output 1: S flip-flop.
- ar_ld, ar_inc, ar_clr, pc_inc, pc_clr, ir_ld, sc_clr outputs 1 each: datapath control strobes.

Function
REQ-003 SC SHALL be a 4-bit register: cleared when sc_clr=1, else incremented when S=1, else held; 15 SHALL wrap to 0.
REQ-004 T and D SHALL be combinational decodes of SC and ir[14:12]; all strobes SHALL be combinational, are gated by S, and take effect at the next clk edge.
REQ-005 Fetch (R=0), while S=1, SHALL assert:
- T0: ar_ld (AR<-PC).
- T1: ir_ld and pc_inc.
- T2: ar_ld (AR<-IR[11:0]), and I<=ir[15] at that edge.
REQ-006 At T3, while S=1:
- D7=0 and I=1: ar_ld (indirect AR<-M[AR]).
- D7=0 and I=0: no strobe.
- D7=1: sc_clr.
REQ-007 Memory-reference completion SHALL be:
- D0 (AND), D1 (ADD), D2 (LDA): sc_clr at T5.
- D3 (STA), D4 (BUN): sc_clr at T4.
- D5 (BSA): ar_inc at T4, sc_clr at T5.
- D6 (ISZ): sc_clr at T6.
REQ-008 Halt: at T3 with D7=1, I=0 and ir[0]=1, S SHALL clear at that edge; SC is also cleared, so the block idles at T0.
REQ-009 start=1 SHALL set S at the next edge; start during S=1 SHALL have no effect; start and HLT in the same cycle SHALL leave S=1.
REQ-010 Strobes SHALL be mutually consistent: ar_ld, ar_inc and ar_clr are never asserted together.

Reset
REQ-011 rst=1 SHALL asynchronously force SC=0, S=0, I=0, and R=0, IEN=0 when present.
REQ-012 While rst=1 or S=0, T SHALL equal 16'h0001 and every strobe SHALL be 0.
REQ-013 Reset asserted mid-instruction SHALL abort the instruction with no further strobes.

Configuration
REQ-014 Macro MANO_INTERRUPT_EN defined SHALL add the R and IEN flip-flops and the interrupt behaviour below:
- ION: D7, I=1, ir[7], T3 sets IEN.
- IOF: D7, I=1, ir[6], T3 clears IEN.
- R<=1 at any edge where S=1, T0, T1 and T2 are all 0, IEN=1, and (fgi|fgo)=1.
REQ-015 With R=1 the interrupt cycle SHALL replace fetch:
- T0: ar_clr.
- T1: pc_clr.
- T2: pc_inc and sc_clr; IEN<=0 and R<=0 at that edge.
REQ-016 With MANO_INTERRUPT_EN undefined, R and IEN SHALL not exist, fgi/fgo SHALL be ignored, and ar_clr and pc_clr SHALL be tied 0.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Reset, start pulse, ir=16'h7001 -> T0..T3 strobes per REQ-005/006, sc_clr at T3, running=0 after that edge, T=16'h0001 thereafter.
- ir=16'h8123 -> ar_ld at T0, T2 and T3; I=1; sc_clr at T5; next T0 follows.
- ir=16'h5010 -> ar_inc only at T4, sc_clr at T5; ir=16'h6010 -> sc_clr at T6.
- rst pulsed while SC=3 -> SC=0, running=0, all strobes 0 immediately.
- Macro on: ir=16'hF080 sets IEN; then fgi=1 with ir=16'h2010 -> R=1 before the next T0; then ar_clr at T0, pc_clr at T1, pc_inc and sc_clr at T2, IEN=0.
- Macro off: same stimulus -> ar_clr and pc_clr stay 0; normal fetch continues.

Source files
------------

// File: rtl/mano_timing_ctrl.sv
// mano_timing_ctrl: Mano basic-computer sequence counter, run flip-flop and control-strobe decoder.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   ir[15:0]            current IR contents (ir[15]=I, ir[14:12]=opcode, ir[7]/ir[6]=ION/IOF, ir[0]=HLT)
//   start               sets the run flip-flop S
//   fgi, fgo            I/O flags, only used when MANO_INTERRUPT_EN is defined
//   T[15:0]             one-hot timing (16'h0001 whenever S=0)
//   D[7:0]              one-hot decode of ir[14:12]
//   I, running          latched indirect bit, run flip-flop S
//   ar_ld .. sc_clr     combinational datapath strobes, gated by S
// Optional feature: define MANO_INTERRUPT_EN to add the R/IEN flip-flops and the interrupt cycle.
module mano_timing_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic        start,
   input  logic        fgi,
   input  logic        fgo,
   output logic [15:0] T,
   output logic [7:0]  D,
   output logic        I,
   output logic        running,
   output logic        ar_ld,
   output logic        ar_inc,
   output logic        ar_clr,
   output logic        pc_inc,
   output logic        pc_clr,
   output logic        ir_ld,
   output logic        sc_clr
);
   logic [3:0]  r_sc;
   logic        r_s;
   logic        r_i;
   logic [15:0] w_t;
   logic        w_r;
   logic        w_hlt;
   logic        w_unused;
   assign w_t      = 16'h0001 << r_sc;
   assign T        = r_s ? w_t : 16'h0001;
   assign D        = 8'h01 << ir[14:12];
   assign I        = r_i;
   assign running  = r_s;
   assign w_hlt    = r_s & w_t[3] & D[7] & ~r_i & ir[0];
   assign w_unused = ^{fgi, fgo, ir[11:1]};
`ifdef MANO_INTERRUPT_EN
   logic r_r;
   logic r_ien;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_r   <= 1'b0;
         r_ien <= 1'b0;
      end else if (r_s && r_r && w_t[2]) begin
         r_r   <= 1'b0;
         r_ien <= 1'b0;
      end else begin
         // interrupt request is only accepted outside the fetch/interrupt slots T0..T2
         if (r_s && r_sc > 4'd2 && r_ien && (fgi || fgo))
            r_r <= 1'b1;
         if (r_s && w_t[3] && D[7] && r_i)
            r_ien <= ir[7] ? 1'b1 : ir[6] ? 1'b0 : r_ien;
      end
   end
   assign w_r = r_r;
`else
   assign w_r = 1'b0;
`endif
   always_comb begin
      ar_ld  = 1'b0;
      ar_inc = 1'b0;
      ar_clr = 1'b0;
      pc_inc = 1'b0;
      pc_clr = 1'b0;
      ir_ld  = 1'b0;
      sc_clr = 1'b0;
      if (r_s) begin
         ar_clr = w_r & w_t[0];
         pc_clr = w_r & w_t[1];
         ar_ld  = ~w_r & (w_t[0] | w_t[2]) | w_t[3] & ~D[7] & r_i;
         ir_ld  = ~w_r & w_t[1];
         pc_inc = w_r ? w_t[2] : w_t[1];
         ar_inc = w_t[4] & D[5];
         sc_clr = w_r & w_t[2]
                | w_t[3] & D[7]
                | w_t[4] & (D[3] | D[4])
                | w_t[5] & (D[0] | D[1] | D[2] | D[5])
                | w_t[6] & D[6];
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sc <= 4'd0;
         r_s  <= 1'b0;
         r_i  <= 1'b0;
      end else begin
         r_sc <= sc_clr ? 4'd0 : r_s ? r_sc + 4'd1 : r_sc;
         // start wins over a simultaneous HLT
         r_s  <= start | (r_s & ~w_hlt);
         if (r_s && w_t[2] && !w_r)
            r_i <= ir[15];
      end
   end
endmodule
